// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared CPU front-end definitions: FSM encoding, PC/instruction widths and the
// EBREAK encoding.
package rom_fetch_arbiter_pkg;

  localparam int unsigned PcW   = 10;
  localparam int unsigned InstW = 32;

  typedef logic [PcW-1:0]   pc_t;
  typedef logic [InstW-1:0] inst_t;

  localparam inst_t EbreakInsn = 32'h0010_0073;

  typedef enum logic [1:0] {
    StHalt,
    StRun,
    StStep
  } state_e;

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Bundle of ROM, CPU-control, instruction and debug signals around the fetch
// arbiter. The arbiter uses the master modport, its environment the slave.
interface rom_fetch_arbiter_if;
  import rom_fetch_arbiter_pkg::*;

  pc_t   rom_addr;
  inst_t rom_data;
  logic  run;
  logic  step;
  logic  stall;
  logic  redirect_valid;
  pc_t   redirect_pc;
  logic  inst_valid;
  inst_t inst;
  pc_t   inst_pc;
  logic  halted;
  logic  dbg_req;
  pc_t   dbg_addr;
  logic  dbg_ack;
  inst_t dbg_data;

  modport master (
    output rom_addr,
    input  rom_data,
    input  run,
    input  step,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst,
    output inst_pc,
    output halted,
    input  dbg_req,
    input  dbg_addr,
    output dbg_ack,
    output dbg_data
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output run,
    output step,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    input  halted,
    output dbg_req,
    output dbg_addr,
    input  dbg_ack,
    input  dbg_data
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect load beats increment; increment wraps modulo the
// PC width.
module fetch_pc_reg
  import rom_fetch_arbiter_pkg::*;
#(
  parameter pc_t RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  pc_t  load_pc,
  input  logic inc,
  output pc_t  pc
);

  pc_t pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_pc;
    end else if (inc) begin
      pc_q <= pc_q + pc_t'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Instruction fetch FSM sharing one combinational ROM port between the CPU
// fetch path and debug reads.
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter pc_t   RESET_PC    = '0,
  parameter inst_t EBREAK_WORD = EbreakInsn
) (
  input logic               clk,
  input logic               rst,
  rom_fetch_arbiter_if.master bus
);

  state_e state_q, state_d;
  logic   ebreak_hold_q, ebreak_hold_d;
  logic   inst_valid_q;
  inst_t  inst_q;
  pc_t    inst_pc_q;
  logic   halted_q;
  logic   dbg_ack_q;
  inst_t  dbg_data_q;
  pc_t    pc;

  logic fetch_issue;
  logic dbg_grant;
  logic run_eff;

  // After an EBREAK halt, a run level still held high must not restart fetch.
  assign run_eff = bus.run & ~ebreak_hold_q;

  assign fetch_issue = ((state_q == StRun) || (state_q == StStep)) &&
                       !bus.stall && !bus.redirect_valid;

  // The cycle right after an ack is never a grant, so dbg_ack is one cycle wide.
  assign dbg_grant = bus.dbg_req && !fetch_issue && !bus.redirect_valid && !dbg_ack_q;

  assign bus.rom_addr = dbg_grant ? bus.dbg_addr : pc;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (bus.redirect_valid),
    .load_pc (bus.redirect_pc),
    .inc     (fetch_issue),
    .pc      (pc)
  );

  always_comb begin
    state_d       = state_q;
    ebreak_hold_d = ebreak_hold_q;
    unique case (state_q)
      StHalt: begin
        if (!bus.run) ebreak_hold_d = 1'b0;
        if (run_eff) begin
          state_d = StRun;
        end else if (bus.step) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (!bus.run) begin
          state_d = StHalt;
        end else if (fetch_issue && (bus.rom_data == EBREAK_WORD)) begin
          state_d       = StHalt;
          ebreak_hold_d = 1'b1;
        end
      end
      StStep: begin
        if (fetch_issue) state_d = StHalt;
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StHalt;
      ebreak_hold_q <= 1'b0;
      inst_valid_q  <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      halted_q      <= 1'b1;
      dbg_ack_q     <= 1'b0;
      dbg_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      ebreak_hold_q <= ebreak_hold_d;
      halted_q      <= (state_d == StHalt);
      if (fetch_issue) begin
        inst_valid_q <= 1'b1;
        inst_q       <= bus.rom_data;
        inst_pc_q    <= pc;
      end else if (bus.redirect_valid || (state_q == StHalt)) begin
        inst_valid_q <= 1'b0;
      end
      dbg_ack_q <= dbg_grant;
      if (dbg_grant) dbg_data_q <= bus.rom_data;
    end
  end

  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.halted     = halted_q;
  assign bus.dbg_ack    = dbg_ack_q;
  assign bus.dbg_data   = dbg_data_q;

endmodule

// File: doc/rom_fetch_arbiter.md
ROM_FETCH_ARBITER -- requirements
Module: rom_fetch_arbiter

Interface
REQ-001 Parameter RESET_PC, default 0: 10-bit word address loaded into the PC at reset.
REQ-002 Parameter EBREAK_WORD, default 32'h00100073: instruction word that forces a halt.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rom_addr  out  10  word address to the combinational instruction ROM.
REQ-007 rom_data  in  32  ROM data; valid in the same cycle as rom_addr.
REQ-008 run  in  1  level; 1 = free-run fetch, 0 = halt request.
REQ-009 step  in  1  one-cycle pulse; fetch exactly one instruction while halted.
REQ-010 stall  in  1  CPU cannot accept an instruction this cycle.
REQ-011 redirect_valid / redirect_pc  in  1 / 10  branch or jump target from the CPU.
REQ-012 inst_valid / inst / inst_pc  out  1 / 32 / 10  registered fetched instruction and its address.
REQ-013 halted  out  1  1 while the FSM is in HALT.
REQ-014 dbg_req / dbg_addr  in  1 / 10  debug read request; held until acknowledged.
REQ-015 dbg_ack / dbg_data  out  1 / 32  one-cycle acknowledge pulse with the read word.

Function
REQ-016 FSM states: HALT, RUN, STEP; rom_addr = dbg_addr in a debug-grant cycle, otherwise the PC.
REQ-017 HALT -> RUN when run=1; HALT -> STEP on step=1 with run=0; STEP -> HALT after one issued fetch; RUN -> HALT when run=0 or an EBREAK_WORD fetch is issued.
REQ-018 Fetch issues in RUN or STEP when stall=0 and no redirect: next cycle inst=rom_data, inst_pc=PC, inst_valid=1, PC=PC+1 mod 1024 (1023 wraps to 0).
REQ-019 With stall=1 no fetch issues: inst, inst_pc, inst_valid and PC hold.
REQ-020 redirect_valid=1 in any state, including with stall=1: PC=redirect_pc next cycle, inst_valid=0 next cycle, no fetch issues; redirect beats stall, step, run and debug.
REQ-021 An EBREAK_WORD fetch is delivered with inst_valid=1, PC advances, then the FSM sits in HALT until run falls and rises again or step pulses.
REQ-022 In HALT, inst_valid=0 and inst/inst_pc hold their last value.
REQ-023 Debug grant when dbg_req=1 and no fetch issues (HALT, or RUN/STEP with stall=1) and no redirect: dbg_data=rom_data and dbg_ack=1 next cycle.
REQ-024 dbg_ack is a single-cycle pulse; the cycle after an ack grants no new debug read even if dbg_req is still 1.
REQ-025 In RUN with stall=0, fetch has strict priority and a debug request waits indefinitely.
REQ-026 step while in RUN or STEP is ignored; step and run=1 together in HALT enter RUN.
REQ-027 Fetch and debug grant never occur in the same cycle.

Reset
REQ-028 rst=1 forces state=HALT, PC=RESET_PC, inst_valid=0, inst=0, inst_pc=0, dbg_ack=0, dbg_data=0, halted=1.
REQ-029 Reset mid-fetch or mid-debug discards the pending transaction, with no ack or valid afterwards.
REQ-030 rst has priority over every input.

Structure
REQ-031 A shared cpu package holds the FSM state encoding, PC width (10), instruction width (32) and the EBREAK constant.
REQ-032 One sub-module, fetch_pc_reg, holds the PC with increment, wrap and redirect load; the FSM and arbitration stay in the top module.

Verification
REQ-033 Reset, run=1, ROM words 0..2 = 0x00200293, 0x01100313, 0x00849493 -> inst_valid in cycles 1..3 with inst_pc 0,1,2 and those words.
REQ-034 Run, stall=1 for 3 cycles at PC=5 -> inst and inst_pc=4 held, no PC change, fetch of PC 5 on release.
REQ-035 redirect_valid=1, redirect_pc=12, with stall=1 -> next cycle inst_valid=0, then inst_pc=12 delivered.
REQ-036 ROM word 7 = 0x00100073 -> fetched with inst_valid=1, halted=1 the following cycle, PC=8; one step pulse fetches word 8 only.
REQ-037 Halted, dbg_req=1 with dbg_addr=13 -> dbg_ack=1 for one cycle with dbg_data = ROM[13]; in RUN with stall=0 dbg_ack stays 0 until stall=1.
REQ-038 PC=1023 in RUN -> fetch of 1023 then fetch of 0; rst mid-debug-request -> no dbg_ack and PC=RESET_PC.
